// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes and the multiply sequencer state encoding.
// Used by the EX-stage ALU and by mul_sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator registers
// plus the per-step partial-product adder (BITS_PER_CYCLE multiplier bits per step).
module mul_shift_add_dp import alu_ctrl_pkg::*; #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_mplierZero
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_mplierNext;

  // Multiplicand times the low multiplier bits, built from shifted copies; modulo 2^WIDTH.
  always_comb begin
    w_partial = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (r_mplier[b]) begin
        w_partial = w_partial + (r_mcand << b);
      end
    end
  end

  assign w_mplierNext = r_mplier >> BITS_PER_CYCLE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (i_step) begin
      r_acc    <= r_acc + w_partial;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= w_mplierNext;
    end
  end

  assign o_acc        = r_acc;
  assign o_mplierZero = (w_mplierNext == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL controller beside the EX-stage ALU; stalls the pipeline until the product is ready.
// Optional macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer import alu_ctrl_pkg::*; #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
`ifdef EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  mul_state_e       r_state;
  mul_state_e       w_nextState;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_acc;
  logic             w_start;
  logic             w_lastStep;
  logic             w_mplierZero;
  logic             w_load;
  logic             w_step;
  logic             w_stall;
  logic             w_busy;
  logic             w_valid;

  assign w_start    = req_i && (ALUCtrl_i == ALU_MUL) && !flush_i;
  assign w_lastStep = (r_count == CW'(N - 1)) || (EARLY_TERM && w_mplierZero);

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_stall     = 1'b0;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_load      = 1'b1;
          w_stall     = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        // A flush beats completion and releases the pipeline in the same cycle.
        if (flush_i) begin
          w_nextState = IDLE;
        end else begin
          w_step  = 1'b1;
          w_stall = 1'b1;
          if (w_lastStep) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_valid     = !flush_i;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_count <= '0;
      end else if (w_step) begin
        r_count <= r_count + CW'(1);
      end
      if (w_valid) begin
        r_data <= w_acc;
      end
    end
  end

  mul_shift_add_dp #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_dp (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_mcand      (data1_i),
    .i_mplier     (data2_i),
    .o_acc        (w_acc),
    .o_mplierZero (w_mplierZero)
  );

  assign stall_o = w_stall;
  assign busy_o  = w_busy;
  assign valid_o = w_valid;
  // The accumulator is shown in the valid cycle; otherwise the last delivered product is held.
  assign data_o  = w_valid ? w_acc : r_data;

endmodule
